// File: rtl/iiitb_ptvm_multi.sv
// Multi-fare parking ticket vending machine: coin credit accumulation, fare sale,
// and greedy one-coin-per-cycle change return on overpayment, cancel or inactivity timeout.
module iiitb_ptvm_multi #(
  parameter int unsigned              CREDIT_W    = 8,
  parameter int unsigned              COIN1_VAL   = 5,
  parameter int unsigned              COIN2_VAL   = 10,
  parameter int unsigned              COIN3_VAL   = 20,
  parameter int unsigned              NUM_TICKETS = 4,
  parameter logic [8*NUM_TICKETS-1:0] PRICES      = {8'd50, 8'd40, 8'd25, 8'd15},
  parameter int unsigned              MAX_CREDIT  = 200,
  parameter int unsigned              TIMEOUT     = 255,
  localparam int unsigned             SEL_W       = $clog2(NUM_TICKETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    out_type,
  output logic                sel_nack,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [CREDIT_W-1:0] C1    = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C2    = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] C3    = CREDIT_W'(COIN3_VAL);
  localparam logic [CREDIT_W:0]   MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [IDLE_W-1:0]   TO_C  = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE
  } state_e;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;

  logic                  out_q, out_d;
  logic [SEL_W-1:0]      out_type_q, out_type_d;
  logic                  sel_nack_q, sel_nack_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  change_valid_q, change_valid_d;
  logic [1:0]            change_coin_q, change_coin_d;
  logic                  busy_q, busy_d;

  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W:0]     coin_sum;
  logic [CREDIT_W-1:0]   price;
  logic                  sel_ok;
  logic                  coin_ok;
  logic                  nack;
  logic [CREDIT_W-1:0]   chg_val;
  logic [1:0]            chg_code;
  logic [IDLE_W-1:0]     idle_inc;
  logic                  timeout_hit;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NUM_TICKETS; i++) begin
      if (idx == SEL_W'(i)) p = CREDIT_W'(PRICES[8*i +: 8]);
    end
    return p;
  endfunction

  // Event decode shared by the next-state and output logic.
  always_comb begin
    coin_val = '0;
    case (in)
      2'd1:    coin_val = C1;
      2'd2:    coin_val = C2;
      2'd3:    coin_val = C3;
      default: coin_val = '0;
    endcase
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    price    = price_of(sel);
    sel_ok   = (32'(sel) < NUM_TICKETS) && (credit_q >= price);

    // A coin is only taken when nothing else claims the cycle and it fits under the ceiling.
    coin_ok = (in != 2'd0) && !cancel && !sel_valid && (coin_sum <= MAX_C) &&
              ((state_q == S_IDLE) || (state_q == S_COLLECT));

    nack = sel_valid && ((state_q == S_IDLE) ||
                         ((state_q == S_COLLECT) && !cancel && !sel_ok));

    chg_val  = '0;
    chg_code = 2'd0;
    if (credit_q >= C3) begin
      chg_val  = C3;
      chg_code = 2'd3;
    end else if (credit_q >= C2) begin
      chg_val  = C2;
      chg_code = 2'd2;
    end else if (credit_q >= C1) begin
      chg_val  = C1;
      chg_code = 2'd1;
    end

    idle_inc    = idle_q + 1'b1;
    timeout_hit = (idle_inc == TO_C);
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    idle_d   = idle_q;
    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          idle_d   = '0;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          idle_d  = '0;
          state_d = S_CHANGE;
        end else if (sel_valid) begin
          idle_d = '0;
          if (sel_ok) begin
            credit_d = credit_q - price;
            state_d  = S_VEND;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          idle_d   = '0;
        end else if (credit_q == '0) begin
          idle_d  = '0;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          idle_d  = '0;
          state_d = S_CHANGE;
        end else begin
          idle_d = idle_inc;
        end
      end
      S_VEND: begin
        state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        // A residue smaller than the smallest coin is dropped so the FSM cannot stall.
        if ((chg_val == '0) || (credit_q == chg_val)) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end else begin
          credit_d = credit_q - chg_val;
        end
      end
      default: begin
        credit_d = '0;
        idle_d   = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_comb begin
    out_d          = (state_d == S_VEND);
    out_type_d     = (state_d == S_VEND) ? sel : '0;
    sel_nack_d     = nack;
    coin_reject_d  = (in != 2'd0) && !coin_ok;
    change_valid_d = (state_q == S_CHANGE) && (chg_val != '0);
    change_coin_d  = (state_q == S_CHANGE) ? chg_code : 2'd0;
    busy_d         = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      idle_q         <= '0;
      out_q          <= 1'b0;
      out_type_q     <= '0;
      sel_nack_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      idle_q         <= idle_d;
      out_q          <= out_d;
      out_type_q     <= out_type_d;
      sel_nack_q     <= sel_nack_d;
      coin_reject_q  <= coin_reject_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      busy_q         <= busy_d;
    end
  end

  assign out          = out_q;
  assign out_type     = out_type_q;
  assign sel_nack     = sel_nack_q;
  assign coin_reject  = coin_reject_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iiitb_ptvm_multi.sv
// Self-checking bench for iiitb_ptvm_multi: vector table, directed multi-cycle
// sequences (reset mid-refund, timeout, credit ceiling) and a randomized run against a queue model.
module tb_iiitb_ptvm_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] in_c = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic       out;
  logic [1:0] out_type;
  logic       sel_nack;
  logic       coin_reject;
  logic       change_valid;
  logic [1:0] change_coin;
  logic [7:0] credit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  iiitb_ptvm_multi #(
    .CREDIT_W   (8),
    .COIN1_VAL  (5),
    .COIN2_VAL  (10),
    .COIN3_VAL  (20),
    .NUM_TICKETS(4),
    .PRICES     ({8'd50, 8'd40, 8'd25, 8'd15}),
    .MAX_CREDIT (200),
    .TIMEOUT    (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in_c),
    .sel_valid   (sel_valid),
    .sel         (sel),
    .cancel      (cancel),
    .out         (out),
    .out_type    (out_type),
    .sel_nack    (sel_nack),
    .coin_reject (coin_reject),
    .change_valid(change_valid),
    .change_coin (change_coin),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int c; bit v; int s; bit x;
    int o; int ot; int nk; int rj; int cv; int cc; int cr; int bz;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(int c, bit v, int s, bit x, int o, int ot, int nk,
                              int rj, int cv, int cc, int cr, int bz);
    vec_t r;
    r.c = c; r.v = v; r.s = s; r.x = x;
    r.o = o; r.ot = ot; r.nk = nk; r.rj = rj; r.cv = cv; r.cc = cc; r.cr = cr; r.bz = bz;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int o, input int ot, input int nk,
                            input int rj, input int cv, input int cc, input int cr, input int bz);
    chk({tag, ".out"}, int'(out), o);
    if (o != 0) chk({tag, ".out_type"}, int'(out_type), ot);
    chk({tag, ".sel_nack"}, int'(sel_nack), nk);
    chk({tag, ".coin_reject"}, int'(coin_reject), rj);
    chk({tag, ".change_valid"}, int'(change_valid), cv);
    if (cv != 0) chk({tag, ".change_coin"}, int'(change_coin), cc);
    chk({tag, ".credit"}, int'(credit), cr);
    chk({tag, ".busy"}, int'(busy), bz);
  endtask

  // Drive one cycle of inputs, clock it, and leave the bench 1 ns after the edge.
  task automatic drive(input int c, input bit v, input int s, input bit x);
    in_c = c[1:0];
    sel_valid = v;
    sel = s[1:0];
    cancel = x;
    @(posedge clk);
    #1;
    in_c = 2'd0;
    sel_valid = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  int price_tab[4] = '{15, 25, 40, 50};
  int m_credit, m_idle;
  bit m_collect, m_vend;
  int m_q[$];
  int e_out, e_type, e_nack, e_rej, e_cv, e_cc, e_cr, e_bz;

  function automatic int cval(input int c);
    case (c)
      1: return 5;
      2: return 10;
      3: return 20;
      default: return 0;
    endcase
  endfunction

  task automatic refund(input int amount);
    int r;
    r = amount;
    while (r >= 20) begin m_q.push_back(3); r -= 20; end
    while (r >= 10) begin m_q.push_back(2); r -= 10; end
    while (r >= 5)  begin m_q.push_back(1); r -= 5;  end
  endtask

  task automatic model_reset();
    m_credit = 0; m_idle = 0; m_collect = 0; m_vend = 0;
    m_q.delete();
  endtask

  task automatic model_step(input int c, input bit v, input int s, input bit x);
    int val;
    bit ok;
    e_out = 0; e_type = 0; e_nack = 0; e_rej = 0; e_cv = 0; e_cc = 0;
    val = cval(c);
    if (m_vend) begin
      e_rej = (c != 0);
      m_vend = 0;
      if (m_credit > 0) refund(m_credit);
    end else if (m_q.size() > 0) begin
      e_rej = (c != 0);
      e_cv = 1;
      e_cc = m_q.pop_front();
      m_credit -= cval(e_cc);
    end else begin
      ok = (c != 0) && !x && !v && (m_credit + val <= 200);
      e_rej = (c != 0) && !ok;
      if (!m_collect) begin
        if (v) e_nack = 1;
        else if (ok) begin m_credit += val; m_collect = 1; m_idle = 0; end
      end else if (x) begin
        refund(m_credit);
        m_collect = 0;
        m_idle = 0;
      end else if (v) begin
        m_idle = 0;
        if (m_credit >= price_tab[s]) begin
          m_credit -= price_tab[s];
          m_vend = 1;
          m_collect = 0;
          e_out = 1;
          e_type = s;
        end else begin
          e_nack = 1;
        end
      end else if (ok) begin
        m_credit += val;
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == 255) begin
          refund(m_credit);
          m_collect = 0;
          m_idle = 0;
        end
      end
    end
    e_cr = m_credit;
    e_bz = (m_vend || m_q.size() > 0) ? 1 : 0;
  endtask

  initial begin
    int hit, ncoins, csum;

    do_reset();
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // c v s x | out type nack rej cv coin credit busy
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  5, 0));
    tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 0));
    tab.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
    tab.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 0));
    tab.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 40, 0));
    tab.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 15, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  5, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
    tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0));
    tab.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 10, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  5, 0));
    tab.push_back(mk(3, 1, 3, 0, 0, 0, 1, 1, 0, 0,  5, 0));
    tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 0));
    tab.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0,  0, 1));
    tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    tab.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0));

    foreach (tab[i]) begin
      drive(tab[i].c, tab[i].v, tab[i].s, tab[i].x);
      check_outs($sformatf("vec%0d", i), tab[i].o, tab[i].ot, tab[i].nk, tab[i].rj,
                 tab[i].cv, tab[i].cc, tab[i].cr, tab[i].bz);
    end

    // Credit ceiling: ten 20-coins reach 200, the eleventh bounces.
    do_reset();
    for (int i = 0; i < 10; i++) drive(3, 0, 0, 0);
    chk("ceiling.credit", int'(credit), 200);
    drive(3, 0, 0, 0);
    chk("ceiling.reject", int'(coin_reject), 1);
    chk("ceiling.credit_held", int'(credit), 200);
    drive(3, 1, 3, 0);
    chk("ceiling.sell_reject", int'(coin_reject), 1);
    chk("ceiling.sell_out", int'(out), 1);
    chk("ceiling.sell_type", int'(out_type), 3);
    chk("ceiling.sell_credit", int'(credit), 150);
    ncoins = 0;
    csum = 0;
    for (int n = 0; n < 30; n++) begin
      drive(0, 0, 0, 0);
      if (change_valid) begin ncoins++; csum += cval(int'(change_coin)); end
      if (!busy) break;
    end
    chk("ceiling.change_count", ncoins, 8);
    chk("ceiling.change_sum", csum, 150);
    chk("ceiling.drained", int'(credit), 0);
    chk("ceiling.idle", int'(busy), 0);

    // Inactivity timeout, plain.
    do_reset();
    drive(1, 0, 0, 0);
    hit = -1;
    for (int k = 1; k <= 400 && hit < 0; k++) begin
      drive(0, 0, 0, 0);
      if (busy) hit = k;
    end
    chk("timeout.cycles", hit, 255);
    drive(0, 0, 0, 0);
    chk("timeout.cv", int'(change_valid), 1);
    chk("timeout.coin", int'(change_coin), 1);
    chk("timeout.credit", int'(credit), 0);

    // Inactivity timeout restarted by a coin at cycle 100.
    do_reset();
    drive(1, 0, 0, 0);
    hit = -1;
    for (int k = 1; k <= 500 && hit < 0; k++) begin
      drive((k == 100) ? 1 : 0, 0, 0, 0);
      if (busy) hit = k;
    end
    chk("timeout_restart.cycles", hit, 355);
    chk("timeout_restart.credit", int'(credit), 10);
    drive(0, 0, 0, 0);
    chk("timeout_restart.cv", int'(change_valid), 1);
    chk("timeout_restart.coin", int'(change_coin), 2);
    chk("timeout_restart.credit0", int'(credit), 0);

    // Asynchronous reset while refunding 15.
    do_reset();
    drive(1, 0, 0, 0);
    drive(2, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("rst_mid.busy_before", int'(busy), 1);
    chk("rst_mid.credit_before", int'(credit), 15);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.credit", int'(credit), 0);
    chk("rst_mid.cv", int'(change_valid), 0);
    chk("rst_mid.busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    check_outs("rst_after", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_outs("rst_coin", 0, 0, 0, 0, 0, 0, 5, 0);

    // Randomized run against the queue model, with periodic quiet stretches for timeouts.
    do_reset();
    model_reset();
    for (int i = 0; i < 4500; i++) begin
      int c, s;
      bit v, x;
      if ((i % 1500) >= 1200) begin
        c = 0; v = 0; x = 0; s = 0;
      end else begin
        c = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3)) : 0;
        v = ($urandom_range(0, 15) == 0);
        x = ($urandom_range(0, 31) == 0);
        s = int'($urandom_range(0, 3));
      end
      model_step(c, v, s, x);
      drive(c, v, s, x);
      check_outs($sformatf("rand%0d", i), e_out, e_type, e_nack, e_rej, e_cv, e_cc, e_cr, e_bz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
